// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: word/tag types, opcodes, instr_type bit indices,
// branch/load mask bit positions and the per-lane decoded record.
package decode_pipe_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  tag_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam int IT_REG        = 0;
  localparam int IT_IMM        = 1;
  localparam int IT_LUI        = 2;
  localparam int IT_AUIPC      = 3;
  localparam int IT_JAL        = 4;
  localparam int IT_JALR       = 5;
  localparam int IT_BRANCH     = 6;
  localparam int IT_LOAD       = 7;
  localparam int IT_STORE      = 8;
  localparam int IT_ADD_OR_SUB = 9;
  localparam int RANGE_INSTRS  = 10;

  localparam int BR_EQ  = 0;
  localparam int BR_NE  = 1;
  localparam int BR_LT  = 2;
  localparam int BR_GE  = 3;
  localparam int BR_LTU = 4;
  localparam int BR_GEU = 5;
  localparam int BR_W   = 6;

  localparam int LD_BYTE   = 0;
  localparam int LD_HWORD  = 1;
  localparam int LD_WORD   = 2;
  localparam int LD_UBYTE  = 3;
  localparam int LD_UHWORD = 4;
  localparam int LD_W      = 5;

  typedef struct packed {
    logic [RANGE_INSTRS-1:0] instr_type;
    logic [BR_W-1:0]         branch_type;
    logic [LD_W-1:0]         load_type;
    tag_t                    rd;
    word_t                   imm;
    word_t                   pc;
    logic                    illegal;
  } dec_t;

endpackage

// File: rtl/decode_lane.sv
// Purely combinational decode of one instruction word into class bits,
// branch/load masks and a sign-extended immediate.
module decode_lane
  import decode_pipe_pkg::*;
(
  input  word_t line_i,
  input  word_t pc_i,
  output dec_t  dec_o
);

  logic [2:0] f3;
  assign f3 = line_i[14:12];

  always_comb begin
    dec_o    = '0;
    dec_o.rd = line_i[11:7];
    dec_o.pc = pc_i;
    case (line_i[6:0])
      OP_REG: begin
        dec_o.instr_type[IT_REG]        = 1'b1;
        dec_o.instr_type[IT_ADD_OR_SUB] = (line_i[31:25] == 7'h20);
      end
      OP_IMM: begin
        dec_o.instr_type[IT_IMM] = 1'b1;
        dec_o.imm = {{20{line_i[31]}}, line_i[31:20]};
      end
      OP_LUI: begin
        dec_o.instr_type[IT_LUI] = 1'b1;
        dec_o.imm = {line_i[31:12], 12'h000};
      end
      OP_AUIPC: begin
        dec_o.instr_type[IT_AUIPC] = 1'b1;
        dec_o.imm = {line_i[31:12], 12'h000};
      end
      OP_JAL: begin
        dec_o.instr_type[IT_JAL] = 1'b1;
        dec_o.imm = {{11{line_i[31]}}, line_i[31], line_i[19:12], line_i[20], line_i[30:21], 1'b0};
      end
      OP_JALR: begin
        dec_o.instr_type[IT_JALR] = 1'b1;
        dec_o.imm = {{20{line_i[31]}}, line_i[31:20]};
      end
      OP_BRANCH: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.instr_type[IT_BRANCH] = 1'b1;
          dec_o.imm = {{19{line_i[31]}}, line_i[31], line_i[7], line_i[30:25], line_i[11:8], 1'b0};
          case (f3)
            3'd0:    dec_o.branch_type[BR_EQ]  = 1'b1;
            3'd1:    dec_o.branch_type[BR_NE]  = 1'b1;
            3'd4:    dec_o.branch_type[BR_LT]  = 1'b1;
            3'd5:    dec_o.branch_type[BR_GE]  = 1'b1;
            3'd6:    dec_o.branch_type[BR_LTU] = 1'b1;
            default: dec_o.branch_type[BR_GEU] = 1'b1;
          endcase
        end
      end
      OP_LOAD: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.instr_type[IT_LOAD] = 1'b1;
          dec_o.imm = {{20{line_i[31]}}, line_i[31:20]};
          case (f3)
            3'd0:    dec_o.load_type[LD_BYTE]   = 1'b1;
            3'd1:    dec_o.load_type[LD_HWORD]  = 1'b1;
            3'd2:    dec_o.load_type[LD_WORD]   = 1'b1;
            3'd4:    dec_o.load_type[LD_UBYTE]  = 1'b1;
            default: dec_o.load_type[LD_UHWORD] = 1'b1;
          endcase
        end
      end
      OP_STORE: begin
        if (f3 > 3'd2) begin
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.instr_type[IT_STORE] = 1'b1;
          dec_o.imm = {{20{line_i[31]}}, line_i[31:25], line_i[11:7]};
        end
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// Multi-lane decode stage: LANES decode_lane instances feeding a 2-entry skid
// buffer, so in_ready comes straight from a flop.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  word_t [LANES-1:0]                   in_line,
  input  word_t                               in_pc,
  output tag_t  [LANES-1:0]                   rs1_async,
  output tag_t  [LANES-1:0]                   rs2_async,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic  [LANES-1:0][RANGE_INSTRS-1:0] instr_type,
  output logic  [LANES-1:0][BR_W-1:0]         branch_type,
  output logic  [LANES-1:0][LD_W-1:0]         load_type,
  output tag_t  [LANES-1:0]                   rd,
  output word_t [LANES-1:0]                   imm,
  output word_t [LANES-1:0]                   pc,
  output logic  [LANES-1:0]                   illegal
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic              in_ready_q;
  dec_t [LANES-1:0]  dec_w;
  dec_t [LANES-1:0]  out_q;
  dec_t [LANES-1:0]  skid_q;
  logic              accept;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    decode_lane u_lane (
      .line_i (in_line[gi]),
      .pc_i   (in_pc + word_t'(4 * gi)),
      .dec_o  (dec_w[gi])
    );
    assign rs1_async[gi]   = in_line[gi][19:15];
    assign rs2_async[gi]   = in_line[gi][24:20];
    assign instr_type[gi]  = out_q[gi].instr_type;
    assign branch_type[gi] = out_q[gi].branch_type;
    assign load_type[gi]   = out_q[gi].load_type;
    assign rd[gi]          = out_q[gi].rd;
    assign imm[gi]         = out_q[gi].imm;
    assign pc[gi]          = out_q[gi].pc;
    assign illegal[gi]     = out_q[gi].illegal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      // Held contents are dropped by invalidation; stale fields are harmless.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_q       <= dec_w;
            out_valid_q <= 1'b1;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (accept && out_ready) begin
            out_q <= dec_w;
          end else if (accept) begin
            skid_q     <= dec_w;
            in_ready_q <= 1'b0;
            state_q    <= SKID;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= FULL;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe (LANES=2): directed instruction vectors with
// hand-computed decode results, backpressure, flush and reset scenarios.
module tb_decode_pipe;
  localparam int L  = 2;
  localparam int NV = 10;
  localparam int LW = 91;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [L-1:0][31:0] in_line;
  logic [31:0]        in_pc;
  logic [L-1:0][4:0]  rs1_async, rs2_async, rd;
  logic [L-1:0][9:0]  instr_type;
  logic [L-1:0][5:0]  branch_type;
  logic [L-1:0][4:0]  load_type;
  logic [L-1:0][31:0] imm, pc;
  logic [L-1:0]       illegal;

  decode_pipe #(.LANES(L)) u_dut (
    .clock(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_line(in_line), .in_pc(in_pc), .rs1_async(rs1_async), .rs2_async(rs2_async),
    .out_valid(out_valid), .out_ready(out_ready), .instr_type(instr_type),
    .branch_type(branch_type), .load_type(load_type), .rd(rd), .imm(imm), .pc(pc),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Hand-decoded vector table
  logic [31:0] t_ins [NV];
  logic [9:0]  t_ty  [NV];
  logic [5:0]  t_br  [NV];
  logic [4:0]  t_ld  [NV];
  logic [4:0]  t_rd  [NV];
  logic [31:0] t_imm [NV];
  logic        t_ill [NV];

  logic [2*LW-1:0] sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic tv(input int i, input logic [31:0] ins, input logic [9:0] ty, input logic [5:0] br,
                    input logic [4:0] ld, input logic [4:0] r, input logic [31:0] im, input logic il);
    t_ins[i] = ins; t_ty[i] = ty; t_br[i] = br; t_ld[i] = ld; t_rd[i] = r; t_imm[i] = im; t_ill[i] = il;
  endtask

  task automatic chk(input string name, input logic [2*LW-1:0] act, input logic [2*LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] exp_lane(input int i, input logic [31:0] lpc);
    return {t_ty[i], t_br[i], t_ld[i], t_rd[i], t_imm[i], lpc, t_ill[i]};
  endfunction

  function automatic logic [2*LW-1:0] exp_bundle(input int i, input logic [31:0] bpc);
    return {exp_lane((i + 1) % NV, bpc + 32'd4), exp_lane(i, bpc)};
  endfunction

  function automatic logic [2*LW-1:0] act_bundle();
    logic [2*LW-1:0] a;
    for (int k = 0; k < L; k++)
      a[k*LW +: LW] = {instr_type[k], branch_type[k], load_type[k], rd[k], imm[k], pc[k], illegal[k]};
    return a;
  endfunction

  // Monitor: pop and compare on each handshake; also checks hold stability
  logic            stall_q = 1'b0;
  logic [2*LW-1:0] held_q;
  always @(negedge clk) begin
    if (stall_q && out_valid) chk("hold_stable", act_bundle(), held_q);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got %h expected no bundle", act_bundle());
      end else begin
        chk("bundle", act_bundle(), sb.pop_front());
      end
    end
    stall_q = out_valid && !out_ready;
    held_q  = act_bundle();
  end

  task automatic send(input int i, input logic [31:0] bpc);
    in_line[0] = t_ins[i];
    in_line[1] = t_ins[(i + 1) % NV];
    in_pc      = bpc;
    in_valid   = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sb.push_back(exp_bundle(i, bpc));
        #1 in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: got in_ready=0 expected accept of vector %0d", i);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk);
      #2;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    tv(0, 32'h00500093, 10'h002, 6'h00, 5'h00, 5'd1,  32'h00000005, 1'b0); // addi x1,x0,5
    tv(1, 32'h123450B7, 10'h004, 6'h00, 5'h00, 5'd1,  32'h12345000, 1'b0); // lui
    tv(2, 32'hFE000EE3, 10'h040, 6'h01, 5'h00, 5'd29, 32'hFFFFFFFC, 1'b0); // beq -4
    tv(3, 32'h0020E463, 10'h040, 6'h10, 5'h00, 5'd8,  32'h00000008, 1'b0); // bltu +8
    tv(4, 32'h0040D183, 10'h080, 6'h00, 5'h10, 5'd3,  32'h00000004, 1'b0); // lhu
    tv(5, 32'h0000007F, 10'h000, 6'h00, 5'h00, 5'd0,  32'h00000000, 1'b1); // bad opcode
    tv(6, 32'h407302B3, 10'h201, 6'h00, 5'h00, 5'd5,  32'h00000000, 1'b0); // sub
    tv(7, 32'h0020A423, 10'h100, 6'h00, 5'h00, 5'd8,  32'h00000008, 1'b0); // sw
    tv(8, 32'h0000B083, 10'h000, 6'h00, 5'h00, 5'd1,  32'h00000000, 1'b1); // load f3=3
    tv(9, 32'h010000EF, 10'h010, 6'h00, 5'h00, 5'd1,  32'h00000010, 1'b0); // jal +16

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_line = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_fields", act_bundle(), 0);

    // Register-file read tags: bltu (rs1=1,rs2=2) and lhu (rs1=1,rs2 field=4)
    in_line[0] = t_ins[3]; in_line[1] = t_ins[4];
    #1;
    chk("rs1_async", rs1_async, {5'd1, 5'd1});
    chk("rs2_async", rs2_async, {5'd4, 5'd2});

    // Single-cycle latency from accept to out_valid
    @(posedge clk); #1;
    send(0, 32'h100);
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    chk("lane0_pc", pc[0], 32'h100);
    @(posedge clk); #1 out_ready = 1'b1;

    // Back-to-back stream through all vectors
    for (int i = 1; i < NV; i++) send(i, 32'h1000 + 32'(i * 16));
    wait_drain();

    // Backpressure: second accept fills the skid and drops in_ready
    @(posedge clk); #1 out_ready = 1'b0;
    send(2, 32'h300);
    @(negedge clk);
    chk("ready_after_1st", in_ready, 1);
    @(posedge clk); #1;
    send(3, 32'h310);
    @(negedge clk);
    chk("ready_after_2nd", in_ready, 0);
    fork
      begin
        send(4, 32'h320);
        send(6, 32'h330);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush while in SKID with a bundle offered in the same cycle
    @(posedge clk); #1 out_ready = 1'b0;
    send(5, 32'h400);
    send(7, 32'h410);
    in_line[0] = t_ins[8]; in_line[1] = t_ins[9]; in_pc = 32'h420;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_no_output", out_valid, 0);

    // Lane 1 PC offset, then reset while FULL
    @(posedge clk); #1 out_ready = 1'b0;
    send(1, 32'h200);
    @(negedge clk);
    chk("lane1_pc", pc[1], 32'h204);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_full_out_valid", out_valid, 0);
    chk("rst_full_fields", act_bundle(), 0);
    chk("rst_full_in_ready", in_ready, 1);

    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter LANES: default 1, legal 1..4; number of instructions decoded per bundle.
REQ-002 SHALL have port clock: input, 1 bit; sole clock, all state on posedge.
REQ-003 SHALL have port reset: input, 1 bit; synchronous, active-high.
REQ-004 SHALL have port flush: input, 1 bit; discards all held bundles.
REQ-005 SHALL have port in_valid: input, 1 bit; bundle offered.
REQ-006 SHALL have port in_ready: output, 1 bit; bundle accepted when in_valid && in_ready.
REQ-007 SHALL have port in_line: input, LANES x word; instruction per lane, lane 0 oldest.
REQ-008 SHALL have port in_pc: input, word; PC of lane 0; lane k PC = in_pc + 4k.
REQ-009 SHALL have port rs1_async / rs2_async: output, LANES x tag; combinational line[19:15] / line[24:20] of in_line, for register-file read.
REQ-010 SHALL have port out_valid: output, 1 bit; decoded bundle present.
REQ-011 SHALL have port out_ready: input, 1 bit; consumer takes bundle when out_valid && out_ready.
REQ-012 SHALL have per-lane output instr_type: LANES x range_instrs; one-hot class plus add_or_sub.
REQ-013 SHALL have per-lane output branch_type: LANES x 6; eq/ne/lt/ge/ltu/geu mask.
REQ-014 SHALL have per-lane output load_type: LANES x 5; byte/hword/word/ubyte/uhword mask.
REQ-015 SHALL have per-lane outputs rd (LANES x tag), imm (LANES x word), pc (LANES x word) and illegal (LANES x 1).

Function
REQ-016 Decode classes SHALL be reg, imm, lui, auipc, jal, jalr, branch, load, store; add_or_sub set only for reg op with funct7 = 0x20.
REQ-017 Immediates SHALL be sign-extended: I for imm/load/jalr; S for store; B and J with bit 0 = 0; U = line[31:12] followed by 12 zeros.
REQ-018 illegal SHALL be 1 for an unlisted opcode, branch funct3 2/3, load funct3 3/6/7, or store funct3 > 2; all class bits SHALL be 0 when illegal.
REQ-019 branch_type and load_type SHALL be all-zero when the lane is not branch/load, never X.
REQ-020 Buffering SHALL use a 2-entry skid buffer with states EMPTY, FULL (output reg valid) and SKID (output and skid reg valid).
REQ-021 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID, driven from a register only.
REQ-022 In EMPTY, on accept, the bundle SHALL be decoded into the output reg and the state SHALL go to FULL; latency from accept to out_valid SHALL be 1 cycle.
REQ-023 In FULL, accept with out_ready SHALL replace the output reg and stay FULL; accept without out_ready SHALL load the skid reg and go to SKID; out_ready without accept SHALL go to EMPTY.
REQ-024 In SKID, out_ready SHALL move the skid reg into the output reg and go to FULL.
REQ-025 Bundles SHALL leave in acceptance order, with none dropped or duplicated.
REQ-026 flush SHALL force EMPTY next cycle, overriding any simultaneous accept or out_ready; a bundle offered in the flush cycle SHALL be discarded.
REQ-027 Output fields SHALL hold stable while out_valid && !out_ready.

Reset
REQ-028 Reset SHALL force EMPTY, out_valid = 0, in_ready = 1.
REQ-029 Reset SHALL clear all decoded output fields to 0, and it SHALL take precedence over flush and handshakes.
REQ-030 Reset mid-operation SHALL discard both buffered bundles.

Structure
REQ-031 Opcodes, instr_type bit indices, branch/load masks, and the word/tag types SHALL live in the shared definitions package/header, extended with the new classes and unsigned masks.
REQ-032 Per-lane combinational decode SHALL be sub-module decode_lane, instantiated LANES times; decode_pipe SHALL hold only the skid FSM and registers.

Verification
REQ-033 Scenario: LANES=1, 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, do_imm, rd=1, imm=5, pc=0x100.
REQ-034 Scenario: 0x123450B7 (lui x1) -> do_lui, imm=0x12345000; 0xFE000EE3 (beq, offset -4) -> do_branch, eq mask, imm=0xFFFFFFFC.
REQ-035 Scenario: bltu (funct3 6) -> ltu mask; lhu (funct3 5) -> uhword mask; 0x0000007F -> illegal=1, all class bits 0.
REQ-036 Scenario: stream of 4 bundles with out_ready held 0 -> in_ready falls after the 2nd accept; releasing out_ready drains bundles 1 and 2 in order with no loss.
REQ-037 Scenario: flush asserted in SKID together with in_valid -> next cycle out_valid=0, in_ready=1, and the offered bundle never appears.
REQ-038 Scenario: LANES=2, pc 0x200 -> lane1 pc=0x204; reset asserted in FULL -> next cycle out_valid=0 and all fields 0.
